// File: rtl/inst_dispatch.sv
// Instruction dispatcher: pops instructions from a show-ahead queue, launches the
// load engine (ILC) and then the write-back engine (W2C), and counts retirements.
module inst_dispatch #(
    parameter int INST_LEN = 160,
    parameter int ADDR_W   = 36,
    parameter int LEN_W    = 9,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [INST_LEN-1:0] instruct,
    input  logic                inst_empty,
    output logic                inst_req,
    output logic                ilc_start,
    output logic [ADDR_W-1:0]   ilc_st_addr,
    output logic [LEN_W-1:0]    ilc_linelen,
    input  logic                ilc_done,
    output logic                w2c_start,
    output logic [ADDR_W-1:0]   w2c_st_addr,
    output logic [LEN_W-1:0]    w2c_linelen,
    input  logic                w2c_done,
    output logic                busy,
    output logic [CNT_W-1:0]    inst_count
);
    localparam int ILC_ADDR_LSB = 0;
    localparam int ILC_LEN_LSB  = 37;
    localparam int W2C_BACK_BIT = 60;
    localparam int W2C_ADDR_LSB = 61;
    localparam int W2C_LEN_LSB  = 97;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_ILC,
        S_WAIT_ILC,
        S_ISSUE_W2C,
        S_WAIT_W2C,
        S_RETIRE
    } state_t;

    state_t              r_state;
    logic [INST_LEN-1:0] r_inst_q;
    logic [CNT_W-1:0]    r_inst_count;
    logic                r_ilc_start;
    logic                r_w2c_start;
    logic                r_fetch_en;

    logic                w_pop;
    logic                w_ilc_needed;
    logic                w_w2c_needed;
    logic                w_unused_bits;

    // Fetch is held off until the first edge after reset release, so a pop can
    // never coincide with reset or with the release cycle itself.
    assign w_pop        = r_fetch_en && (r_state == S_IDLE) && run && !inst_empty;
    assign w_ilc_needed = |r_inst_q[ILC_LEN_LSB +: LEN_W];
    assign w_w2c_needed = r_inst_q[W2C_BACK_BIT] && (|r_inst_q[W2C_LEN_LSB +: LEN_W]);
    assign w_unused_bits = ^{r_inst_q[36], r_inst_q[59:46], r_inst_q[INST_LEN-1:106]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_inst_q     <= '0;
            r_inst_count <= '0;
            r_ilc_start  <= 1'b0;
            r_w2c_start  <= 1'b0;
            r_fetch_en   <= 1'b0;
        end else begin
            r_fetch_en  <= 1'b1;
            r_ilc_start <= 1'b0;
            r_w2c_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_inst_q    <= instruct;
                        r_ilc_start <= |instruct[ILC_LEN_LSB +: LEN_W];
                        r_state     <= S_ISSUE_ILC;
                    end
                end
                S_ISSUE_ILC: begin
                    if (w_ilc_needed) begin
                        r_state <= S_WAIT_ILC;
                    end else if (w_w2c_needed) begin
                        r_w2c_start <= 1'b1;
                        r_state     <= S_ISSUE_W2C;
                    end else begin
                        r_state <= S_RETIRE;
                    end
                end
                S_WAIT_ILC: begin
                    // w2c_done here is deliberately ignored, even alongside ilc_done
                    if (ilc_done) begin
                        if (w_w2c_needed) begin
                            r_w2c_start <= 1'b1;
                            r_state     <= S_ISSUE_W2C;
                        end else begin
                            r_state <= S_RETIRE;
                        end
                    end
                end
                S_ISSUE_W2C: begin
                    r_state <= S_WAIT_W2C;
                end
                S_WAIT_W2C: begin
                    if (w2c_done) begin
                        r_state <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    r_inst_count <= r_inst_count + CNT_W'(1);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_req    = w_pop;
    assign ilc_start   = r_ilc_start;
    assign w2c_start   = r_w2c_start;
    assign busy        = (r_state != S_IDLE);
    assign inst_count  = r_inst_count;
    assign ilc_st_addr = r_inst_q[ILC_ADDR_LSB +: ADDR_W];
    assign ilc_linelen = r_inst_q[ILC_LEN_LSB +: LEN_W];
    assign w2c_st_addr = r_inst_q[W2C_ADDR_LSB +: ADDR_W];
    assign w2c_linelen = r_inst_q[W2C_LEN_LSB +: LEN_W];

endmodule

// File: tb/tb_inst_dispatch.sv
// Bench for inst_dispatch: table-driven single instructions, hand-written corner
// sequences, and a randomized run checked against a per-instruction scoreboard.
module tb_inst_dispatch;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst, run, inst_empty, ilc_done, w2c_done;
    logic [159:0]   instruct;
    logic           inst_req, ilc_start, w2c_start, busy;
    logic [35:0]    ilc_st_addr, w2c_st_addr;
    logic [8:0]     ilc_linelen, w2c_linelen;
    logic [CW-1:0]  inst_count;

    inst_dispatch #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .instruct(instruct), .inst_empty(inst_empty),
        .inst_req(inst_req), .ilc_start(ilc_start), .ilc_st_addr(ilc_st_addr),
        .ilc_linelen(ilc_linelen), .ilc_done(ilc_done), .w2c_start(w2c_start),
        .w2c_st_addr(w2c_st_addr), .w2c_linelen(w2c_linelen), .w2c_done(w2c_done),
        .busy(busy), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] a1;
        logic [8:0]  l1;
        logic        wb;
        logic [35:0] a2;
        logic [8:0]  l2;
        int d; int e; int spur;
        int exp_ilc; int exp_w2c; int exp_lat;
    } vec_t;

    logic [159:0] q[$];
    logic [44:0]  exp_ilc_q[$], exp_w2c_q[$];
    logic [35:0]  obs_ilc_addr[$];
    logic [35:0]  last_w2c_addr;
    logic [8:0]   last_w2c_len, last_ilc_len;
    logic [35:0]  last_ilc_addr;
    int ilc_dly = 1, w2c_dly = 1, ilc_cd = -1, w2c_cd = -1, spur_cd = -1, spur_off = 0;
    logic force_ilc = 1'b0, force_w2c = 1'b0, sb_on = 1'b0;
    int cyc = 0, n_pop, n_ilc, n_w2c, t_pop, t_idle, retired = 0;
    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic clr_obs();
        n_pop = 0; n_ilc = 0; n_w2c = 0; t_pop = -1; t_idle = -1;
        obs_ilc_addr.delete();
    endtask

    function automatic logic [159:0] make_inst(input logic [35:0] a1, input logic [8:0] l1,
                                               input logic wb, input logic [35:0] a2,
                                               input logic [8:0] l2);
        logic [159:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom};
        v[35:0] = a1; v[45:37] = l1; v[60] = wb; v[96:61] = a2; v[105:97] = l2;
        return v;
    endfunction

    // One clock: drive inputs, sample outputs at negedge, pop the model queue at posedge.
    task automatic step();
        logic s_req;
        inst_empty = (q.size() == 0);
        instruct   = inst_empty ? {$urandom, $urandom, $urandom, $urandom, $urandom} : q[0];
        ilc_done   = (ilc_cd == 0) || force_ilc;
        w2c_done   = (w2c_cd == 0) || (spur_cd == 0) || force_w2c;
        if (ilc_cd >= 0) ilc_cd--;
        if (w2c_cd >= 0) w2c_cd--;
        if (spur_cd >= 0) spur_cd--;
        force_ilc = 1'b0; force_w2c = 1'b0;
        @(negedge clk);
        cyc++;
        s_req = inst_req;
        if (s_req) begin
            n_pop++; t_pop = cyc; t_idle = -1;
            check("req_nonempty", {63'd0, inst_empty}, 64'd0);
            check("req_in_idle", {63'd0, busy}, 64'd0);
        end
        if (ilc_start) begin
            n_ilc++;
            last_ilc_addr = ilc_st_addr; last_ilc_len = ilc_linelen;
            obs_ilc_addr.push_back(ilc_st_addr);
            ilc_cd = ilc_dly - 1;
            if (spur_off > 0) spur_cd = spur_off - 1;
            if (sb_on) begin
                if (exp_ilc_q.size() == 0) check("ilc_unexpected", 64'd1, 64'd0);
                else check("ilc_sb", {19'd0, ilc_linelen, ilc_st_addr}, {19'd0, exp_ilc_q.pop_front()});
            end
        end
        if (w2c_start) begin
            n_w2c++;
            last_w2c_addr = w2c_st_addr; last_w2c_len = w2c_linelen;
            w2c_cd = w2c_dly - 1;
            if (sb_on) begin
                if (exp_w2c_q.size() == 0) check("w2c_unexpected", 64'd1, 64'd0);
                else check("w2c_sb", {19'd0, w2c_linelen, w2c_st_addr}, {19'd0, exp_w2c_q.pop_front()});
            end
        end
        if (!busy && t_pop >= 0 && cyc > t_pop && t_idle < 0) t_idle = cyc;
        @(posedge clk);
        if (s_req) void'(q.pop_front());
        #1;
    endtask

    task automatic hold_reset();
        rst = 1'b1; run = 1'b0;
        ilc_cd = -1; w2c_cd = -1; spur_cd = -1; spur_off = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        retired = 0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_outs"}, {inst_req, ilc_start, w2c_start, busy}, 64'd0);
        check({nm, "_addr"}, {ilc_st_addr, w2c_st_addr}, 64'd0);
        check({nm, "_len"}, {46'd0, ilc_linelen, w2c_linelen}, 64'd0);
        check({nm, "_cnt"}, {60'd0, inst_count}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{36'h0ABCDEF01, 9'd8,   1'b0, 36'h5555,      9'd3,   1, 1, 0, 1, 0, 4};
        vecs[1] = '{36'h000001000, 9'd8,   1'b0, 36'h0,         9'd0,   3, 1, 0, 1, 0, 6};
        vecs[2] = '{36'h777,       9'd0,   1'b0, 36'h888,       9'd9,   1, 1, 0, 0, 0, 3};
        vecs[3] = '{36'h400,       9'd16,  1'b1, 36'h123,       9'd16,  2, 2, 0, 1, 1, 8};
        vecs[4] = '{36'h0,         9'd0,   1'b1, 36'h9ABCDEF12, 9'd5,   1, 3, 0, 0, 1, 7};
        vecs[5] = '{36'h321,       9'd4,   1'b1, 36'h654,       9'd0,   1, 1, 0, 1, 0, 4};
        vecs[6] = '{36'hFFFFFFFFF, 9'h1FF, 1'b1, 36'hFFFFFFFFF, 9'h1FF, 1, 1, 0, 1, 1, 6};
        vecs[7] = '{36'h10,        9'd8,   1'b1, 36'h20,        9'd8,   4, 1, 2, 1, 1, 9};
        vecs[8] = '{36'h30,        9'd8,   1'b1, 36'h40,        9'd8,   3, 2, 3, 1, 1, 9};
        vecs[9] = '{36'h50,        9'd2,   1'b0, 36'h60,        9'd7,   2, 1, 0, 1, 0, 5};

        rst = 1'b1; run = 1'b1; inst_empty = 1'b0; instruct = '1;
        ilc_done = 1'b0; w2c_done = 1'b0;
        #1;
        check_all_zero("reset");
        hold_reset();
        check_all_zero("post_release");

        // Table: one instruction at a time, latency measured pop -> back in IDLE.
        for (int i = 0; i < 10; i++) begin
            clr_obs();
            ilc_dly = vecs[i].d; w2c_dly = vecs[i].e; spur_off = vecs[i].spur;
            q.push_back(make_inst(vecs[i].a1, vecs[i].l1, vecs[i].wb, vecs[i].a2, vecs[i].l2));
            run = 1'b1;
            for (int k = 0; k < 60 && t_idle < 0; k++) step();
            run = 1'b0;
            retired++;
            check($sformatf("v%0d_done", i), {63'd0, t_idle >= 0}, 64'd1);
            check($sformatf("v%0d_pops", i), n_pop, 1);
            check($sformatf("v%0d_ilc_n", i), n_ilc, vecs[i].exp_ilc);
            check($sformatf("v%0d_w2c_n", i), n_w2c, vecs[i].exp_w2c);
            check($sformatf("v%0d_lat", i), t_idle - t_pop, vecs[i].exp_lat);
            check($sformatf("v%0d_cnt", i), inst_count, retired % 16);
            if (vecs[i].exp_ilc == 1)
                check($sformatf("v%0d_ilc_f", i), {last_ilc_len, last_ilc_addr}, {vecs[i].l1, vecs[i].a1});
            if (vecs[i].exp_w2c == 1)
                check($sformatf("v%0d_w2c_f", i), {last_w2c_len, last_w2c_addr}, {vecs[i].l2, vecs[i].a2});
            $display("vec %0d: ilc=%0d w2c=%0d lat=%0d cnt=%0d", i, n_ilc, n_w2c, t_idle - t_pop, inst_count);
            spur_off = 0;
        end

        // Two ILC-only instructions queued back to back, done 3 cycles after start.
        clr_obs(); ilc_dly = 3; w2c_dly = 1;
        q.push_back(make_inst(36'hA0A0, 9'd8, 1'b0, 36'h1, 9'd4));
        q.push_back(make_inst(36'hB0B0, 9'd8, 1'b0, 36'h2, 9'd4));
        run = 1'b1;
        for (int k = 0; k < 80 && !(n_pop == 2 && t_idle >= 0); k++) step();
        retired += 2;
        check("pair_pops", n_pop, 2);
        check("pair_ilc_n", n_ilc, 2);
        check("pair_addr0", obs_ilc_addr.size() > 0 ? obs_ilc_addr[0] : 36'd0, 36'hA0A0);
        check("pair_addr1", obs_ilc_addr.size() > 1 ? obs_ilc_addr[1] : 36'd0, 36'hB0B0);
        check("pair_w2c_n", n_w2c, 0);
        check("pair_cnt", inst_count, retired % 16);
        step();
        check("pair_busy", {63'd0, busy}, 64'd0);
        $display("pair: pops=%0d cnt=%0d", n_pop, inst_count);

        // Spurious done pulses while idle.
        clr_obs(); run = 1'b0;
        force_ilc = 1'b1; step();
        force_w2c = 1'b1; step();
        force_ilc = 1'b1; force_w2c = 1'b1; step();
        step();
        check("spur_idle_busy", {63'd0, busy}, 64'd0);
        check("spur_idle_cnt", inst_count, retired % 16);
        check("spur_idle_starts", n_ilc + n_w2c, 0);
        $display("idle spurious dones: busy=%0b", busy);

        // run dropped right after the pop: the instruction finishes, fetch stops.
        clr_obs(); ilc_dly = 2;
        q.push_back(make_inst(36'hC1, 9'd8, 1'b0, 36'h0, 9'd0));
        q.push_back(make_inst(36'hC2, 9'd8, 1'b0, 36'h0, 9'd0));
        run = 1'b1;
        for (int k = 0; k < 10 && n_pop == 0; k++) step();
        run = 1'b0;
        repeat (20) step();
        retired++;
        check("halt_pops", n_pop, 1);
        check("halt_cnt", inst_count, retired % 16);
        check("halt_q", q.size(), 1);
        check("halt_busy", {63'd0, busy}, 64'd0);
        run = 1'b1;
        for (int k = 0; k < 30 && !(n_pop == 2 && t_idle >= 0); k++) step();
        run = 1'b0;
        retired++;
        check("resume_cnt", inst_count, retired % 16);
        $display("run halt: pops=%0d cnt=%0d", n_pop, inst_count);

        // Asynchronous reset while waiting on write-back.
        clr_obs(); ilc_dly = 1; w2c_dly = 50;
        q.push_back(make_inst(36'hD1, 9'd8, 1'b1, 36'hD2, 9'd8));
        q.push_back(make_inst(36'hE1, 9'd8, 1'b0, 36'h0, 9'd0));
        run = 1'b1;
        for (int k = 0; k < 20 && n_w2c == 0; k++) step();
        run = 1'b0;
        step(); step();
        check("wait_w2c_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        w2c_dly = 1;
        hold_reset();
        clr_obs();
        check("rst_q_kept", q.size(), 1);
        repeat (5) step();
        check("rst_no_activity", n_pop + n_ilc + n_w2c, 0);
        check("rst_cnt0", inst_count, 0);
        run = 1'b1;
        for (int k = 0; k < 30 && !(n_pop == 1 && t_idle >= 0); k++) step();
        run = 1'b0;
        retired++;
        check("rst_resume_addr", last_ilc_addr, 36'hE1);
        check("rst_resume_cnt", inst_count, retired % 16);
        $display("async reset: cnt=%0d", inst_count);

        // Counter wrap: 17 retirements on a 4-bit counter.
        hold_reset();
        clr_obs();
        for (int i = 0; i < 17; i++) q.push_back(make_inst(36'h1 + 36'(i), 9'd0, 1'b0, 36'h0, 9'd0));
        run = 1'b1;
        for (int k = 0; k < 200 && !(n_pop == 17 && t_idle >= 0); k++) step();
        run = 1'b0;
        check("wrap_pops", n_pop, 17);
        check("wrap_cnt", inst_count, 1);
        retired = 17;
        $display("wrap: cnt=%0d", inst_count);

        // Randomized: expectations built per instruction from its fields alone.
        clr_obs(); sb_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            logic [8:0]  l1, l2;
            logic        wb;
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            l1 = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            l2 = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            wb = 1'($urandom_range(0, 1));
            q.push_back(make_inst(ra[35:0], l1, wb, rb[35:0], l2));
            if (l1 != 0) exp_ilc_q.push_back({l1, ra[35:0]});
            if (wb && l2 != 0) exp_w2c_q.push_back({l2, rb[35:0]});
        end
        for (int k = 0; k < 4000 && !(n_pop == 40 && t_idle >= 0); k++) begin
            run = ($urandom_range(0, 9) < 7);
            ilc_dly = $urandom_range(1, 4);
            w2c_dly = $urandom_range(1, 4);
            force_ilc = ($urandom_range(0, 31) == 0);
            force_w2c = ($urandom_range(0, 31) == 0);
            step();
        end
        run = 1'b0;
        retired += 40;
        check("rand_pops", n_pop, 40);
        check("rand_ilc_left", exp_ilc_q.size(), 0);
        check("rand_w2c_left", exp_w2c_q.size(), 0);
        check("rand_cnt", inst_count, retired % 16);
        $display("random: pops=%0d ilc=%0d w2c=%0d cnt=%0d", n_pop, n_ilc, n_w2c, inst_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
